// File: rtl/univ_shift_reg.sv
// univ_shift_reg: multi-cycle universal shift register (LSL/LSR/ASR/ROR), one bit per clock
module univ_shift_reg #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q,
   output logic             so,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [AMT_W-1:0] cnt;
   logic [1:0]       md;
   logic [WIDTH-1:0] nq;
   logic             nso;
   always_comb begin
      nq  = md == 2'b00 ? {q[WIDTH-2:0], 1'b0}
                        : {md == 2'b10 ? q[WIDTH-1] : md == 2'b11 ? q[0] : 1'b0, q[WIDTH-1:1]};
      nso = md == 2'b00 ? q[WIDTH-1] : q[0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         so    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         md    <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  q  <= din;
                  so <= 1'b0;
               end else if (start) begin
                  md    <= mode;
                  cnt   <= amt;
                  so    <= 1'b0;
                  state <= amt == '0 ? DONE : SHIFT;
                  done  <= amt == '0;
                  busy  <= amt != '0;
               end
            end
            SHIFT: begin
               q   <= nq;
               so  <= nso;
               cnt <= cnt - 1'b1;
               if (cnt == AMT_W'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, data register width (>=2).
REQ-002 SHALL provide parameter: AMT_W, 5, shift-amount width; shift amounts above WIDTH are not supported.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous reset, active-high, sampled on rising clk edge.
REQ-005 SHALL have port: load  input  1  parallel-load request, sampled in IDLE only.
REQ-006 SHALL have port: din  input  WIDTH  parallel-load data.
REQ-007 SHALL have port: start  input  1  shift-operation request, sampled in IDLE only.
REQ-008 SHALL have port: amt  input  AMT_W  number of 1-bit shift steps, sampled with start.
REQ-009 SHALL have port: mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; sampled with start.
REQ-010 SHALL have port: q  output  WIDTH  register contents.
REQ-011 SHALL have port: so  output  1  last bit shifted out (rotated-out bit for ROR).
REQ-012 SHALL have port: busy  output  1  high while in SHIFT.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; outputs registered, no combinational input-to-output path.
REQ-015 In IDLE, load=1 SHALL set q<=din and so<=0, state stays IDLE; load has priority over start.
REQ-016 In IDLE, start=1 with load=0 SHALL latch mode, set counter<=amt, so<=0; q unchanged on this edge.
REQ-017 start with amt=0 SHALL go IDLE->DONE directly; otherwise IDLE->SHIFT.
REQ-018 In SHIFT, each edge SHALL perform exactly one 1-bit step per latched mode and decrement counter.
REQ-019 LSL: q<={q[WIDTH-2:0],0}, so<=q[WIDTH-1].
REQ-020 LSR: q<={0,q[WIDTH-1:1]}, so<=q[0].
REQ-021 ASR: q<={q[WIDTH-1],q[WIDTH-1:1]}, so<=q[0].
REQ-022 ROR: q<={q[0],q[WIDTH-1:1]}, so<=q[0].
REQ-023 SHIFT->DONE on the edge performing the final step (counter==1); no extra step ever performed.
REQ-024 done SHALL be 1 exactly during DONE (one cycle), DONE->IDLE unconditionally next edge.
REQ-025 Latency: done high in the cycle beginning amt+1 edges after the start edge (1 edge for amt=0).
REQ-026 load, start, amt, mode, din SHALL be ignored in SHIFT and DONE; no queuing of requests.
REQ-027 busy SHALL be 1 only in SHIFT; busy and done never simultaneously high.
REQ-028 q and so SHALL hold value in IDLE (absent load) and DONE.

Reset
REQ-029 rst=1 SHALL, on the next rising edge, force q=0, so=0, busy=0, done=0, counter=0, state=IDLE.
REQ-030 rst SHALL override all other inputs and any state, including mid-SHIFT and DONE; aborted operation produces no done pulse.
REQ-031 First load/start SHALL be accepted on the first edge with rst=0.

Verification (WIDTH=8, AMT_W=4)
REQ-032 Reset: hold rst 2 cycles with load=1,din=8'hFF -> q=8'h00, so=0, busy=0, done=0.
REQ-033 LSL: load 8'hA5; start amt=3 mode=00 -> busy 3 cycles, then q=8'h28, so=1, done pulse 1 cycle.
REQ-034 ASR/ROR: load 8'h96, start amt=2 mode=10 -> q=8'hE5, so=1; load 8'h81, start amt=1 mode=11 -> q=8'hC0, so=1.
REQ-035 amt=0: load 8'h3C, start amt=0 -> done next cycle, busy never high, q=8'h3C, so=0.
REQ-036 Ignore while busy: start amt=4 mode=01 on 8'hF0, pulse load din=8'h11 and start during SHIFT -> q=8'h0F, single done pulse.
REQ-037 Reset mid-op: start amt=5, assert rst in 2nd SHIFT cycle -> q=8'h00, IDLE, no done pulse.
